// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit ID encodings, header field layout helpers and
// the injector state encoding.
package noc_pkg;

  localparam logic [1:0] FlitBody     = 2'b00;
  localparam logic [1:0] FlitTail     = 2'b01;
  localparam logic [1:0] FlitHead     = 2'b10;
  localparam logic [1:0] FlitHeadTail = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StPayload
  } inj_state_e;

  // Header layout from LSB: dst_x, dst_y, src_x, src_y, len.
  function automatic int unsigned hdr_dst_y_off(input int unsigned x_w);
    return x_w;
  endfunction

  function automatic int unsigned hdr_src_x_off(input int unsigned x_w, input int unsigned y_w);
    return x_w + y_w;
  endfunction

  function automatic int unsigned hdr_src_y_off(input int unsigned x_w, input int unsigned y_w);
    return 2 * x_w + y_w;
  endfunction

  function automatic int unsigned hdr_len_off(input int unsigned x_w, input int unsigned y_w);
    return 2 * x_w + 2 * y_w;
  endfunction

  // TAIL and HEAD_TAIL both close a packet; they share id bit 0.
  function automatic logic flit_is_last(input logic [1:0] id);
    return id[0];
  endfunction

endpackage

// File: rtl/flit_out_reg.sv
// Single-entry valid/ready output register: loads when the slot is free,
// holds its contents stable while the consumer stalls.
module flit_out_reg #(
  parameter int unsigned Width = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             slot_free_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  assign slot_free_o = !valid_q || ready_i;
  assign valid_o     = valid_q;
  assign data_o      = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (slot_free_o) begin
      valid_d = load_i;
      if (load_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/xy_packet_injector.sv
// Resource-side packet injector for the XY mesh: turns a request plus payload
// stream into HEAD/BODY/TAIL flits toward the router's resource port.
module xy_packet_injector
  import noc_pkg::*;
#(
  parameter int unsigned X_CORD          = 0,
  parameter int unsigned Y_CORD          = 0,
  parameter int unsigned PACKET_ADDR_X_W = 4,
  parameter int unsigned PACKET_ADDR_Y_W = 4,
  parameter int unsigned LEN_W           = 4,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned PKT_CNT_W       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [PACKET_ADDR_X_W-1:0] req_x_addr_i,
  input  logic [PACKET_ADDR_Y_W-1:0] req_y_addr_i,
  input  logic [LEN_W-1:0]           req_len_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  input  logic [DATA_W-1:0]          data_i,
  output logic [DATA_W+1:0]          flit_o,
  output logic                       flit_valid_o,
  input  logic                       flit_ready_i,
  output logic                       pkt_sent_o,
  output logic [PKT_CNT_W-1:0]       pkt_cnt_o
);

  localparam int unsigned DstYOff = hdr_dst_y_off(PACKET_ADDR_X_W);
  localparam int unsigned SrcXOff = hdr_src_x_off(PACKET_ADDR_X_W, PACKET_ADDR_Y_W);
  localparam int unsigned SrcYOff = hdr_src_y_off(PACKET_ADDR_X_W, PACKET_ADDR_Y_W);
  localparam int unsigned LenOff  = hdr_len_off(PACKET_ADDR_X_W, PACKET_ADDR_Y_W);

  inj_state_e           state_q, state_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic                 sent_q, sent_d;
  logic [PKT_CNT_W-1:0] cnt_q;

  logic                 slot_free;
  logic                 load;
  logic [DATA_W+1:0]    load_flit;
  logic [DATA_W-1:0]    hdr;

  always_comb begin
    hdr = '0;
    hdr[PACKET_ADDR_X_W-1:0]         = req_x_addr_i;
    hdr[DstYOff +: PACKET_ADDR_Y_W]  = req_y_addr_i;
    hdr[SrcXOff +: PACKET_ADDR_X_W]  = PACKET_ADDR_X_W'(X_CORD);
    hdr[SrcYOff +: PACKET_ADDR_Y_W]  = PACKET_ADDR_Y_W'(Y_CORD);
    hdr[LenOff +: LEN_W]             = req_len_i;
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    req_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    load         = 1'b0;
    load_flit    = '0;
    unique case (state_q)
      StIdle: begin
        req_ready_o = slot_free;
        if (req_valid_i && slot_free) begin
          load = 1'b1;
          if (req_len_i == '0) begin
            load_flit = {FlitHeadTail, hdr};
          end else begin
            load_flit = {FlitHead, hdr};
            rem_d     = req_len_i;
            state_d   = StPayload;
          end
        end
      end
      StPayload: begin
        data_ready_o = slot_free;
        if (data_valid_i && slot_free) begin
          load  = 1'b1;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            load_flit = {FlitTail, data_i};
            state_d   = StIdle;
          end else begin
            load_flit = {FlitBody, data_i};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  flit_out_reg #(
    .Width (DATA_W + 2)
  ) u_flit_out_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (load),
    .data_i      (load_flit),
    .ready_i     (flit_ready_i),
    .valid_o     (flit_valid_o),
    .data_o      (flit_o),
    .slot_free_o (slot_free)
  );

  assign sent_d     = flit_valid_o && flit_ready_i && flit_is_last(flit_o[DATA_W+1:DATA_W]);
  assign pkt_sent_o = sent_q;
  assign pkt_cnt_o  = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rem_q   <= '0;
      sent_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sent_q  <= sent_d;
      if (sent_d) begin
        cnt_q <= cnt_q + PKT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xy_packet_injector.sv
// Directed bench for xy_packet_injector at (1,2) with a 2-bit packet counter.
module tb_xy_packet_injector;

  typedef logic [33:0] flit_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_x, req_y, req_len;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data;
  flit_t       flit;
  logic        flit_valid;
  logic        flit_ready;
  logic        pkt_sent;
  logic [1:0]  pkt_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_cnt = 0;

  flit_t      got_flits[$];
  int         got_cyc[$];
  logic [1:0] got_cnt[$];

  xy_packet_injector #(
    .X_CORD          (1),
    .Y_CORD          (2),
    .PACKET_ADDR_X_W (4),
    .PACKET_ADDR_Y_W (4),
    .LEN_W           (4),
    .DATA_W          (32),
    .PKT_CNT_W       (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_x_addr_i (req_x),
    .req_y_addr_i (req_y),
    .req_len_i    (req_len),
    .data_valid_i (data_valid),
    .data_ready_o (data_ready),
    .data_i       (data),
    .flit_o       (flit),
    .flit_valid_o (flit_valid),
    .flit_ready_i (flit_ready),
    .pkt_sent_o   (pkt_sent),
    .pkt_cnt_o    (pkt_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records flits that will be accepted at the next rising edge, and sent pulses.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (flit_valid && flit_ready) begin
        got_flits.push_back(flit);
        got_cyc.push_back(cyc);
      end
      if (pkt_sent) got_cnt.push_back(pkt_cnt);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void clear_logs();
    got_flits.delete();
    got_cyc.delete();
    got_cnt.delete();
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic drive_req(input logic [3:0] x, input logic [3:0] y, input logic [3:0] len);
    bit ok = 0;
    req_valid = 1'b1; req_x = x; req_y = y; req_len = len;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_handshake_timeout got req_ready=0 want 1 within 50 cycles");
    end else begin
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic drive_data(input logic [31:0] d);
    bit ok = 0;
    data_valid = 1'b1; data = d;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (data_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL data_handshake_timeout got data_ready=0 want 1 within 50 cycles");
    end else begin
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; req_x = 0; req_y = 0; req_len = 0;
    data_valid = 0; data = 0; flit_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (flit_valid !== 1'b0 || flit !== '0 || pkt_sent !== 1'b0 || pkt_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b flit=%h sent=%b cnt=%0d want 0 0 0 0",
               flit_valid, flit, pkt_sent, pkt_cnt);
    end
    checks++;
    if (req_ready !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_readies got req_ready=%b data_ready=%b want 1 0", req_ready, data_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_req_ready got %b want 1", req_ready);
    end
    exp_cnt = 0;
    clear_logs();
  endtask

  task automatic test_head_tail();
    clear_logs();
    drive_req(4'd3, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 4;
    checks++;
    if (got_flits.size() != 1) begin
      errors++;
      $display("FAIL head_tail_count got %0d flits want 1", got_flits.size());
    end else if (got_flits[0] !== {2'b11, 32'h0000_2103}) begin
      errors++;
      $display("FAIL head_tail_flit got %h want %h", got_flits[0], {2'b11, 32'h0000_2103});
    end
    checks++;
    if (got_cnt.size() != 1 || got_cnt[0] !== 2'(exp_cnt)) begin
      errors++;
      $display("FAIL head_tail_sent got %0d pulses (first cnt %0d) want 1 pulse cnt %0d",
               got_cnt.size(), (got_cnt.size() > 0) ? got_cnt[0] : 2'd0, exp_cnt);
    end
  endtask

  task automatic test_len3();
    flit_t exp[4];
    exp = '{{2'b10, 32'h0003_2165}, {2'b00, 32'hA}, {2'b00, 32'hB}, {2'b01, 32'hC}};
    clear_logs();
    drive_req(4'd5, 4'd6, 4'd3);
    drive_data(32'hA);
    drive_data(32'hB);
    drive_data(32'hC);
    repeat (3) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 4;
    checks++;
    if (got_flits.size() != 4) begin
      errors++;
      $display("FAIL len3_count got %0d flits want 4", got_flits.size());
    end
    for (int i = 0; i < 4 && i < got_flits.size(); i++) begin
      checks++;
      if (got_flits[i] !== exp[i] || got_cyc[i] != got_cyc[0] + i) begin
        errors++;
        $display("FAIL len3_flit%0d got %h at +%0d want %h at +%0d",
                 i, got_flits[i], got_cyc[i] - got_cyc[0], exp[i], i);
      end
    end
    checks++;
    if (got_cnt.size() != 1 || got_cnt[0] !== 2'(exp_cnt)) begin
      errors++;
      $display("FAIL len3_sent got %0d pulses want 1 with cnt %0d", got_cnt.size(), exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    flit_t exp[4];
    exp = '{{2'b10, 32'h0003_2117}, {2'b00, 32'hA}, {2'b00, 32'hB}, {2'b01, 32'hC}};
    clear_logs();
    fork
      begin
        drive_req(4'd7, 4'd1, 4'd3);
        drive_data(32'hA);
        drive_data(32'hB);
        drive_data(32'hC);
      end
      begin
        bit found = 0;
        flit_t hold;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (flit_valid && flit[33:32] == 2'b00) begin found = 1; break; end
        end
        checks++;
        if (!found) begin
          errors++;
          $display("FAIL stall_body_seen got no BODY flit want one within 20 cycles");
        end else begin
          flit_ready = 1'b0;
          hold = flit;
          repeat (5) begin
            #1;
            checks++;
            if (data_ready !== 1'b0 || req_ready !== 1'b0) begin
              errors++;
              $display("FAIL stall_readies got data_ready=%b req_ready=%b want 0 0",
                       data_ready, req_ready);
            end
            @(negedge clk);
            checks++;
            if (flit_valid !== 1'b1 || flit !== hold) begin
              errors++;
              $display("FAIL stall_hold got valid=%b flit=%h want 1 %h", flit_valid, flit, hold);
            end
          end
        end
        flit_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 4;
    checks++;
    if (got_flits.size() != 4) begin
      errors++;
      $display("FAIL stall_count got %0d flits want 4", got_flits.size());
    end
    for (int i = 0; i < 4 && i < got_flits.size(); i++) begin
      checks++;
      if (got_flits[i] !== exp[i]) begin
        errors++;
        $display("FAIL stall_flit%0d got %h want %h", i, got_flits[i], exp[i]);
      end
    end
    checks++;
    if (got_cnt.size() != 1 || got_cnt[0] !== 2'(exp_cnt)) begin
      errors++;
      $display("FAIL stall_sent got %0d pulses want 1 with cnt %0d", got_cnt.size(), exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    flit_t exp[4];
    int    exp_c[2];
    exp = '{{2'b10, 32'h0001_2122}, {2'b01, 32'h11}, {2'b10, 32'h0001_2100}, {2'b01, 32'h22}};
    clear_logs();
    drive_req(4'd2, 4'd2, 4'd1);
    drive_data(32'h11);
    drive_req(4'd0, 4'd0, 4'd1);
    drive_data(32'h22);
    repeat (3) @(negedge clk);
    exp_c[0] = (exp_cnt + 1) % 4;
    exp_c[1] = (exp_cnt + 2) % 4;
    exp_cnt  = exp_c[1];
    checks++;
    if (got_flits.size() != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d flits want 4", got_flits.size());
    end
    for (int i = 0; i < 4 && i < got_flits.size(); i++) begin
      checks++;
      if (got_flits[i] !== exp[i] || got_cyc[i] != got_cyc[0] + i) begin
        errors++;
        $display("FAIL b2b_flit%0d got %h at +%0d want %h at +%0d",
                 i, got_flits[i], got_cyc[i] - got_cyc[0], exp[i], i);
      end
    end
    checks++;
    if (got_cnt.size() != 2 || got_cnt[0] !== 2'(exp_c[0]) || got_cnt[1] !== 2'(exp_c[1])) begin
      errors++;
      $display("FAIL b2b_sent got %0d pulses want 2 with cnt %0d,%0d",
               got_cnt.size(), exp_c[0], exp_c[1]);
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_logs();
    drive_req(4'd4, 4'd4, 4'd3);
    drive_data(32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (flit_valid !== 1'b0 || pkt_cnt !== 2'd0 || pkt_sent !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got valid=%b cnt=%0d sent=%b want 0 0 0",
               flit_valid, pkt_cnt, pkt_sent);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    clear_logs();
    #1;
    checks++;
    if (req_ready !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_readies got req_ready=%b data_ready=%b want 1 0",
               req_ready, data_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_flits.size() != 0 || got_cnt.size() != 0 || pkt_cnt !== 2'd0) begin
      errors++;
      $display("FAIL midreset_abandon got %0d flits %0d pulses cnt %0d want 0 0 0",
               got_flits.size(), got_cnt.size(), pkt_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] exp[5];
    exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    clear_logs();
    for (int i = 0; i < 5; i++) drive_req(4'd1, 4'd2, 4'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (got_cnt.size() != 5 || got_flits.size() != 5) begin
      errors++;
      $display("FAIL wrap_count got %0d pulses %0d flits want 5 5", got_cnt.size(), got_flits.size());
    end
    for (int i = 0; i < 5 && i < got_cnt.size(); i++) begin
      checks++;
      if (got_cnt[i] !== exp[i]) begin
        errors++;
        $display("FAIL wrap_cnt%0d got %0d want %0d", i, got_cnt[i], exp[i]);
      end
    end
    checks++;
    if (got_flits.size() > 0 && got_flits[0] !== {2'b11, 32'h0000_2121}) begin
      errors++;
      $display("FAIL wrap_self_header got %h want %h", got_flits[0], {2'b11, 32'h0000_2121});
    end
  endtask

  initial begin
    test_reset();
    test_head_tail();
    test_len3();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
